// File: rtl/data_mem_responder.sv
// Single-port data memory slave with a fixed access latency and valid/ready request/response handshakes.
// Optional macro MEM_MISALIGN_CHECK_EN turns misaligned half/word accesses into error responses.
module data_mem_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int AW    = MEM_DEPTH_LOG2 + 2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic                    r_we;
  logic [AW-1:0]           r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [1:0]              r_size;
  logic                    r_unsigned;
  logic                    r_req_ready;
  logic                    r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_resp_rdata;
  logic                    r_resp_err;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                      w_accept;
  logic                      w_enter_resp;
  logic                      w_we;
  logic [AW-1:0]             w_addr;
  logic [DATA_WIDTH-1:0]     w_wdata;
  logic [1:0]                w_size;
  logic                      w_unsigned;
  logic [MEM_DEPTH_LOG2-1:0] w_idx;
  logic [1:0]                w_off;
  logic                      w_misal;
  logic [DATA_WIDTH-1:0]     w_word;
  logic [DATA_WIDTH-1:0]     w_shift;
  logic [DATA_WIDTH-1:0]     w_load;
  logic [DATA_WIDTH-1:0]     w_lanes;
  logic [NB-1:0]             w_be;
  logic                      w_unused_addr;

  assign w_unused_addr = ^req_addr[ADDRESS_WIDTH-1:AW];

  assign w_accept = (r_state == S_IDLE) && req_valid;
  // With zero wait cycles the access happens on the accepting edge, so operands come straight from the request.
  assign w_enter_resp = !rst && (((r_state == S_WAIT) && (r_cnt == 4'd0)) ||
                                 (w_accept && (WAIT_CYCLES == 0)));

  assign w_we       = (r_state == S_IDLE) ? req_we : r_we;
  assign w_addr     = (r_state == S_IDLE) ? req_addr[AW-1:0] : r_addr;
  assign w_wdata    = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_size     = (r_state == S_IDLE) ? req_size : r_size;
  assign w_unsigned = (r_state == S_IDLE) ? req_unsigned : r_unsigned;
  assign w_idx      = w_addr[AW-1:2];
  assign w_word     = r_mem[w_idx];

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misal = ((w_size == 2'b01) && w_addr[0]) || (w_size[1] && (w_addr[1:0] != 2'b00));
`else
  assign w_misal = 1'b0;
`endif

  // Lane offset, alignment, extension and byte enables for the current access
  always_comb begin
    w_off   = 2'b00;
    w_load  = '0;
    w_lanes = w_wdata;
    w_be    = '0;
    case (w_size)
      2'b00:   w_off = w_addr[1:0];
      2'b01:   w_off = {w_addr[1], 1'b0};
      default: w_off = 2'b00;
    endcase
    w_shift = w_word >> {w_off, 3'b000};
    case (w_size)
      2'b00: begin
        w_load  = {{(DATA_WIDTH-8){~w_unsigned & w_shift[7]}}, w_shift[7:0]};
        w_lanes = {NB{w_wdata[7:0]}};
      end
      2'b01: begin
        w_load  = {{(DATA_WIDTH-16){~w_unsigned & w_shift[15]}}, w_shift[15:0]};
        w_lanes = {(NB/2){w_wdata[15:0]}};
      end
      default: begin
        w_load  = w_shift;
        w_lanes = w_wdata;
      end
    endcase
    for (int i = 0; i < NB; i++) begin
      case (w_size)
        2'b00:   w_be[i] = (i == int'(w_off));
        2'b01:   w_be[i] = ((i / 2) == int'(w_off[1]));
        default: w_be[i] = 1'b1;
      endcase
    end
  end

  // Storage write port; commits only on the edge entering RESP, never reset
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_we && !w_misal) begin
      for (int i = 0; i < NB; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][i*8 +: 8] <= w_lanes[i*8 +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_addr      <= req_addr[AW-1:0];
            r_wdata     <= req_wdata;
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= (w_we || w_misal) ? '0 : w_load;
              r_resp_err   <= w_misal;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= (w_we || w_misal) ? '0 : w_load;
            r_resp_err   <= w_misal;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (default parameters, WAIT_CYCLES = 2).
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  data_mem_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full transaction from a negedge in IDLE; latency counts negedges after the accepting edge.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic uns,
                     output logic [31:0] rdata, output logic err, output int l);
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    @(posedge clk);
    l = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      l++;
    end while (!resp_valid && l < 40);
    check_eq("resp_seen", {31'd0, resp_valid}, 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_ready",  {31'd0, req_ready}, 32'd1);
    check_eq("rst_valid",  {31'd0, resp_valid}, 32'd0);
    check_eq("rst_rdata",  resp_rdata, 32'd0);
    check_eq("rst_err",    {31'd0, resp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Basic word store then load
    txn(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, lat);
    check_eq("st_lat", lat, 32'd3);
    check_eq("st_rdata", rd, 32'd0);
    txn(1'b0, 32'h10, 32'd0, 2'b10, 1'b0, rd, er, lat);
    check_eq("ld_lat", lat, 32'd3);
    check_eq("ld_word", rd, 32'hDEADBEEF);
    check_eq("ld_err", {31'd0, er}, 32'd0);

    // Byte lanes and extension
    txn(1'b1, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    txn(1'b1, 32'h13, 32'h80, 2'b00, 1'b0, rd, er, lat);
    txn(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, rd, er, lat);
    check_eq("ld_byte_s", rd, 32'hFFFFFF80);
    txn(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, rd, er, lat);
    check_eq("ld_byte_u", rd, 32'h00000080);
    txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    check_eq("ld_word_b", rd, 32'h80000000);
    txn(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, rd, er, lat);
    check_eq("ld_size3", rd, 32'h80000000);

    // Half lanes
    txn(1'b1, 32'h40, 32'h0, 2'b10, 1'b0, rd, er, lat);
    txn(1'b1, 32'h42, 32'h1234ABCD, 2'b01, 1'b0, rd, er, lat);
    txn(1'b1, 32'h40, 32'h0000005A, 2'b00, 1'b0, rd, er, lat);
    txn(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, rd, er, lat);
    check_eq("ld_word_h", rd, 32'hABCD005A);
    txn(1'b0, 32'h42, 32'h0, 2'b01, 1'b0, rd, er, lat);
    check_eq("ld_half_s", rd, 32'hFFFFABCD);
    txn(1'b0, 32'h42, 32'h0, 2'b01, 1'b1, rd, er, lat);
    check_eq("ld_half_u", rd, 32'h0000ABCD);
    txn(1'b0, 32'h41, 32'h0, 2'b00, 1'b0, rd, er, lat);
    check_eq("ld_byte1", rd, 32'h00000000);

    // Back-pressure in RESP with a competing request held high
    req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b1; req_wdata = 32'h12345678;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq("hold_lat", lat, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_valid", {31'd0, resp_valid}, 32'd1);
      check_eq("hold_rdata", resp_rdata, 32'h80000000);
      check_eq("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("rel_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("rel_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check_eq("no_2nd_req", {31'd0, resp_valid}, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    check_eq("held_st_dropped", rd, 32'h80000000);

    // Reset during WAIT drops the store
    txn(1'b1, 32'h20, 32'h11111111, 2'b10, 1'b0, rd, er, lat);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h22222222; req_size = 2'b10;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("wait_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstw_valid", {31'd0, resp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("rstw_valid2", {31'd0, resp_valid}, 32'd0);
    txn(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lat);
    check_eq("rstw_mem", rd, 32'h11111111);

    // Reset and request on the same edge
    req_we = 1'b0; req_addr = 32'h20; req_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    check_eq("rstreq_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check_eq("rstreq_valid", {31'd0, resp_valid}, 32'd0);

    // Misaligned word load
    txn(1'b0, 32'h22, 32'h0, 2'b10, 1'b0, rd, er, lat);
`ifdef MEM_MISALIGN_CHECK_EN
    check_eq("mis_rdata", rd, 32'h0);
    check_eq("mis_err", {31'd0, er}, 32'd1);
`else
    check_eq("mis_rdata", rd, 32'h11111111);
    check_eq("mis_err", {31'd0, er}, 32'd0);
`endif
    check_eq("mis_lat", lat, 32'd3);

    // Address aliasing
    txn(1'b1, 32'h1004, 32'hCAFEF00D, 2'b10, 1'b0, rd, er, lat);
    txn(1'b0, 32'h4, 32'h0, 2'b10, 1'b0, rd, er, lat);
    check_eq("alias", rd, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
